// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board geometry, FSM state codes and row helpers.
package tetris_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 10;
    localparam int AW   = 4;

    typedef enum logic [2:0] {
        LC_IDLE = 3'd0,
        LC_RD   = 3'd1,
        LC_EV   = 3'd2,
        LC_WR   = 3'd3,
        LC_FILL = 3'd4,
        LC_DONE = 3'd5
    } lc_state_t;

    typedef enum logic [2:0] {
        MF_IDLE  = 3'd0,
        MF_SPAWN = 3'd1,
        MF_FALL  = 3'd2,
        MF_LAND  = 3'd3,
        MF_CLEAR = 3'd4,
        MF_OVER  = 3'd5
    } mf_state_t;

    function automatic logic is_full(input logic [COLS-1:0] row);
        return &row;
    endfunction

endpackage

// File: rtl/line_clear_unit.sv
// Line clear unit: scans the board bottom-up, flags full rows of the landed
// piece, compacts surviving rows downward and zero-fills the vacated top rows.
module line_clear_unit #(
    parameter int ROWS = tetris_pkg::ROWS,
    parameter int COLS = tetris_pkg::COLS,
    parameter int AW   = tetris_pkg::AW
) (
    input  logic            clka,
    input  logic            restart,
    input  logic            start_clear,
    input  logic [AW-1:0]   base_row,
    output logic            busy,
    output logic [3:0]      which_row,
    output logic [2:0]      lines_cleared,
    output logic            clear_done,
    output logic [AW-1:0]   row_addr,
    output logic            row_wr_en,
    output logic [COLS-1:0] row_wr_data,
    input  logic [COLS-1:0] row_rd_data
);
    import tetris_pkg::*;

    lc_state_t       state, next_state;
    logic [AW-1:0]   src, dst, base;
    logic [COLS-1:0] held;
    logic [3:0]      which_q;
    logic [2:0]      lines_q;
    logic            full;
    logic [AW-1:0]   offset;
    logic            in_window;

    assign full      = is_full(row_rd_data);
    assign offset    = src - base;
    assign in_window = (src >= base) && (offset <= AW'(3));

    always_ff @(posedge clka) begin
        if (restart) begin
            state <= LC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LC_IDLE: if (start_clear) next_state = LC_RD;
            LC_RD:   next_state = LC_EV;
            LC_EV: begin
                if (full) begin
                    next_state = (src == '0) ? LC_FILL : LC_RD;
                end else if (src == dst) begin
                    if (src == '0) begin
                        next_state = (lines_q != 3'd0) ? LC_FILL : LC_DONE;
                    end else begin
                        next_state = LC_RD;
                    end
                end else begin
                    next_state = LC_WR;
                end
            end
            LC_WR:   next_state = (src == '0) ? LC_FILL : LC_RD;
            LC_FILL: next_state = (dst == '0) ? LC_DONE : LC_FILL;
            LC_DONE: next_state = LC_IDLE;
            default: next_state = LC_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != LC_IDLE);
        clear_done  = (state == LC_DONE);
        row_addr    = '0;
        row_wr_en   = 1'b0;
        row_wr_data = '0;
        case (state)
            LC_RD:   row_addr = src;
            LC_WR: begin
                row_addr    = dst;
                row_wr_en   = 1'b1;
                row_wr_data = held;
            end
            LC_FILL: begin
                row_addr  = dst;
                row_wr_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan pointers: src walks every row, dst trails it by the number of full rows found.
    always_ff @(posedge clka) begin
        if (restart) begin
            src     <= '0;
            dst     <= '0;
            base    <= '0;
            which_q <= '0;
            lines_q <= '0;
        end else begin
            case (state)
                LC_IDLE: begin
                    if (start_clear) begin
                        base    <= base_row;
                        src     <= AW'(ROWS - 1);
                        dst     <= AW'(ROWS - 1);
                        which_q <= '0;
                        lines_q <= '0;
                    end
                end
                LC_EV: begin
                    if (full) begin
                        if (in_window) which_q[offset[1:0]] <= 1'b1;
                        if (lines_q != 3'd4) lines_q <= lines_q + 3'd1;
                        if (src != '0) src <= src - AW'(1);
                    end else if (src == dst) begin
                        if (src != '0) begin
                            src <= src - AW'(1);
                            dst <= dst - AW'(1);
                        end
                    end
                end
                LC_WR: begin
                    if (src != '0) src <= src - AW'(1);
                    dst <= dst - AW'(1);
                end
                LC_FILL: begin
                    if (dst != '0) dst <= dst - AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Row buffer carries data only, so it is left out of reset.
    always_ff @(posedge clka) begin
        if (state == LC_EV && !full && src != dst) begin
            held <= row_rd_data;
        end
    end

    assign which_row     = which_q;
    assign lines_cleared = lines_q;

endmodule
